// File: rtl/seg_disp_pkg.sv
// Shared definitions for the scanned 7-segment display driver: page codes,
// blank code, segment table, saturation limit and converter FSM states.
package seg_disp_pkg;

  localparam logic [1:0] PAGE_NORMAL = 2'd0;
  localparam logic [1:0] PAGE_OBD    = 2'd1;
  localparam logic [1:0] PAGE_FUEL   = 2'd2;
  localparam logic [1:0] PAGE_AUTO   = 2'd3;

  localparam logic [3:0] BLANK_CODE  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_L  = 3'd1,
    ST_SHIFT_L = 3'd2,
    ST_LOAD_R  = 3'd3,
    ST_SHIFT_R = 3'd4,
    ST_BLANK   = 3'd5,
    ST_COMMIT  = 3'd6
  } conv_state_t;

  // Active-high segments {dp,g,f,e,d,c,b,a}; the blank code lights nothing.
  function automatic logic [7:0] seg_encode(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'h0:    seg = 8'h3F;
      4'h1:    seg = 8'h06;
      4'h2:    seg = 8'h5B;
      4'h3:    seg = 8'h4F;
      4'h4:    seg = 8'h66;
      4'h5:    seg = 8'h6D;
      4'h6:    seg = 8'h7D;
      4'h7:    seg = 8'h07;
      4'h8:    seg = 8'h7F;
      4'h9:    seg = 8'h6F;
      4'hA:    seg = 8'h77;
      4'hB:    seg = 8'h7C;
      4'hC:    seg = 8'h39;
      4'hD:    seg = 8'h5E;
      4'hE:    seg = 8'h79;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  // Largest value representable in the given number of decimal digits.
  function automatic int unsigned sat_limit(input int unsigned digits);
    int unsigned v;
    v = 32'd1;
    for (int unsigned i = 0; i < digits; i++) begin
      v = v * 32'd10;
    end
    return v - 32'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter for one display half: saturates on load,
// shifts VAL_W cycles, presents leading-zero-blanked BCD digits.
module bin2bcd_serial
  import seg_disp_pkg::*;
#(
  parameter int VAL_W = 14,
  parameter int H     = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [VAL_W-1:0] i_value,
  output logic             o_done,
  output logic [4*H-1:0]   o_bcd
);

  localparam int unsigned SAT   = sat_limit(H);
  localparam int          CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] r_bin;
  logic [4*H-1:0]   r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic [VAL_W-1:0] w_load_val;
  logic [4*H-1:0]   w_adj;
  logic [4*H-1:0]   w_blanked;
  logic             w_lead;

  assign w_load_val = (32'(i_value) > SAT) ? VAL_W'(SAT) : i_value;

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < H; i++) begin
      w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
    end
  end

  // Load on start, then one double-dabble step per cycle until the count runs out.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_bin <= w_load_val;
      r_bcd <= '0;
      r_cnt <= CNT_W'(VAL_W);
    end else if (r_cnt != '0) begin
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
      r_cnt          <= r_cnt - CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Blank leading zeros from the MSD down; digit 0 always stays visible.
  always_comb begin
    w_blanked = r_bcd;
    w_lead    = 1'b1;
    for (int i = H - 1; i >= 1; i--) begin
      if (w_lead && (r_bcd[4*i +: 4] == 4'd0)) begin
        w_blanked[4*i +: 4] = BLANK_CODE;
      end else begin
        w_lead = 1'b0;
      end
    end
  end

  // o_done marks the cycle performing the final shift; o_bcd is valid after it.
  assign o_done = (r_cnt == CNT_W'(1));
  assign o_bcd  = w_blanked;

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed two-half 7-segment display driver with serial BCD
// conversion, auto-rotate pages and warning blink. Optional: SEG_LAMP_TEST_EN.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int VAL_W      = 14,
  parameter int ROT_FRAMES = 512
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_tick_scan,
  input  logic                  i_tick_blink,
  input  logic [1:0]            i_page_sel,
  input  logic [13:0]           i_rpm,
  input  logic [7:0]            i_speed,
  input  logic [7:0]            i_fuel,
  input  logic [7:0]            i_temp,
  input  logic [7:0]            i_accel,
  input  logic [1:0]            i_warn_mask,
`ifdef SEG_LAMP_TEST_EN
  input  logic                  i_lamp_test,
`endif
  output logic [7:0]            o_seg_data,
  output logic [NUM_DIGITS-1:0] o_seg_com,
  output logic                  o_conv_busy
);

  localparam int H     = NUM_DIGITS / 2;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FC_W  = $clog2(ROT_FRAMES + 1);

  logic [IDX_W-1:0]        r_scan_idx;
  logic                    r_blink_phase;
  logic [1:0]              r_rot_page;
  logic [FC_W-1:0]         r_frame_cnt;
  conv_state_t             r_state;
  conv_state_t             w_next;
  logic [VAL_W-1:0]        r_snap_right;
  logic [4*H-1:0]          r_left_res;
  logic [4*H-1:0]          r_right_res;
  logic [4*NUM_DIGITS-1:0] r_disp_buf;
  logic [7:0]              r_seg_data;
  logic [NUM_DIGITS-1:0]   r_seg_com;
  logic                    r_conv_busy;

  logic                    w_frame_end;
  logic [1:0]              w_page;
  logic [VAL_W-1:0]        w_left_val;
  logic [VAL_W-1:0]        w_right_val;
  logic                    w_start;
  logic [VAL_W-1:0]        w_start_val;
  logic                    w_done;
  logic [4*H-1:0]          w_bcd;
  logic [3:0]              w_digit;
  logic                    w_blink_off;
  logic [7:0]              w_seg_next;

  assign w_frame_end = i_tick_scan && (r_scan_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_page      = (i_page_sel == PAGE_AUTO) ? r_rot_page : i_page_sel;

  // Left/right source values for the resolved page.
  always_comb begin
    case (w_page)
      PAGE_NORMAL: begin w_left_val = VAL_W'(i_accel); w_right_val = VAL_W'(i_speed); end
      PAGE_OBD:    begin w_left_val = VAL_W'(i_rpm);   w_right_val = VAL_W'(i_temp);  end
      PAGE_FUEL:   begin w_left_val = VAL_W'(i_fuel);  w_right_val = VAL_W'(i_temp);  end
      default:     begin w_left_val = VAL_W'(i_accel); w_right_val = VAL_W'(i_speed); end
    endcase
  end

  // Scan position and blink phase.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_scan_idx    <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (i_tick_scan) begin
        r_scan_idx <= w_frame_end ? '0 : (r_scan_idx + IDX_W'(1));
      end else begin
        r_scan_idx <= r_scan_idx;
      end
      r_blink_phase <= i_tick_blink ? ~r_blink_phase : r_blink_phase;
    end
  end

  // Auto-rotate: count frames while in auto mode, advance the page every ROT_FRAMES.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_frame_cnt <= '0;
      r_rot_page  <= PAGE_NORMAL;
    end else if (i_page_sel != PAGE_AUTO) begin
      r_frame_cnt <= '0;
    end else if (w_frame_end) begin
      if (r_frame_cnt == FC_W'(ROT_FRAMES - 1)) begin
        r_frame_cnt <= '0;
        r_rot_page  <= (r_rot_page == PAGE_FUEL) ? PAGE_NORMAL : (r_rot_page + 2'd1);
      end else begin
        r_frame_cnt <= r_frame_cnt + FC_W'(1);
      end
    end else begin
      r_frame_cnt <= r_frame_cnt;
    end
  end

  // Converter state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_conv_busy <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_conv_busy <= (w_next != ST_IDLE);
    end
  end

  // Converter next state; one shared converter runs left then right.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_start_val = w_left_val;
    case (r_state)
      ST_IDLE:    w_next = w_frame_end ? ST_LOAD_L : ST_IDLE;
      ST_LOAD_L:  begin w_start = 1'b1; w_start_val = w_left_val; w_next = ST_SHIFT_L; end
      ST_SHIFT_L: w_next = w_done ? ST_LOAD_R : ST_SHIFT_L;
      ST_LOAD_R:  begin w_start = 1'b1; w_start_val = r_snap_right; w_next = ST_SHIFT_R; end
      ST_SHIFT_R: w_next = w_done ? ST_BLANK : ST_SHIFT_R;
      ST_BLANK:   w_next = ST_COMMIT;
      ST_COMMIT:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  bin2bcd_serial #(
    .VAL_W (VAL_W),
    .H     (H)
  ) u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_start),
    .i_value (w_start_val),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // Snapshot, per-half result capture and atomic buffer commit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_snap_right <= '0;
      r_left_res   <= '0;
      r_right_res  <= '0;
      r_disp_buf   <= {NUM_DIGITS{BLANK_CODE}};
    end else begin
      if (r_state == ST_LOAD_L) r_snap_right <= w_right_val;
      else                      r_snap_right <= r_snap_right;
      if (r_state == ST_LOAD_R) r_left_res <= w_bcd;
      else                      r_left_res <= r_left_res;
      if (r_state == ST_BLANK)  r_right_res <= w_bcd;
      else                      r_right_res <= r_right_res;
      if (r_state == ST_COMMIT) r_disp_buf <= {r_left_res, r_right_res};
      else                      r_disp_buf <= r_disp_buf;
    end
  end

  assign w_digit     = r_disp_buf[{r_scan_idx, 2'b00} +: 4];
  assign w_blink_off = r_blink_phase &&
                       ((r_scan_idx >= IDX_W'(H)) ? i_warn_mask[1] : i_warn_mask[0]);

  // Segment pattern for the digit currently scanned.
  always_comb begin
    w_seg_next = 8'h00;
`ifdef SEG_LAMP_TEST_EN
    if (i_lamp_test) begin
      w_seg_next = 8'hFF;
    end else if (w_blink_off) begin
      w_seg_next = 8'h00;
    end else begin
      w_seg_next = seg_encode(w_digit);
    end
`else
    if (w_blink_off) begin
      w_seg_next = 8'h00;
    end else begin
      w_seg_next = seg_encode(w_digit);
    end
`endif
  end

  // Registered pin drive.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_seg_data <= 8'h00;
      r_seg_com  <= '1;
    end else begin
      r_seg_data <= w_seg_next;
      r_seg_com  <= ~(NUM_DIGITS'(1) << r_scan_idx);
    end
  end

  assign o_seg_data  = r_seg_data;
  assign o_seg_com   = r_seg_com;
  assign o_conv_busy = r_conv_busy;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: stimulus queues time-stamped
// expectations, a negedge monitor compares them against the pins.
module tb_seg_scan_display;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_tick_scan;
  logic        i_tick_blink;
  logic [1:0]  i_page_sel;
  logic [13:0] i_rpm;
  logic [7:0]  i_speed, i_fuel, i_temp, i_accel;
  logic [1:0]  i_warn_mask;
  logic [7:0]  o_seg_data;
  logic [7:0]  o_seg_com;
  logic        o_conv_busy;

  seg_scan_display #(
    .NUM_DIGITS (8),
    .VAL_W      (14),
    .ROT_FRAMES (2)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_tick_scan  (i_tick_scan),
    .i_tick_blink (i_tick_blink),
    .i_page_sel   (i_page_sel),
    .i_rpm        (i_rpm),
    .i_speed      (i_speed),
    .i_fuel       (i_fuel),
    .i_temp       (i_temp),
    .i_accel      (i_accel),
    .i_warn_mask  (i_warn_mask),
`ifdef SEG_LAMP_TEST_EN
    .i_lamp_test  (1'b0),
`endif
    .o_seg_data   (o_seg_data),
    .o_seg_com    (o_seg_com),
    .o_conv_busy  (o_conv_busy)
  );

  typedef struct {
    int         cyc;
    int         kind;   // 0 scan digit, 1 busy only, 2 reset state
    logic [7:0] com;
    logic [7:0] data;
    logic       busy;
    string      name;
  } item_t;

  item_t      sbq[$];
  int         ncyc  = 0;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] seg_tab [16];
  logic [3:0] m_buf [8];
  int         m_idx;
  logic       m_blink;
  logic [15:0] rot_l [6];
  logic [15:0] rot_r [6];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) ncyc <= ncyc + 1;

  // Monitor: compare every expectation due this cycle, flag any that slipped past.
  always @(negedge i_clk) begin
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].cyc == ncyc) begin
        logic ok;
        case (sbq[k].kind)
          0:       ok = (o_seg_com === sbq[k].com) && (o_seg_data === sbq[k].data);
          1:       ok = (o_conv_busy === sbq[k].busy);
          default: ok = (o_seg_com === sbq[k].com) && (o_seg_data === sbq[k].data) &&
                        (o_conv_busy === sbq[k].busy);
        endcase
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL %s @%0d: got com=%h data=%h busy=%b want com=%h data=%h busy=%b",
                   sbq[k].name, ncyc, o_seg_com, o_seg_data, o_conv_busy,
                   sbq[k].com, sbq[k].data, sbq[k].busy);
        end
        sbq.delete(k);
      end else if (sbq[k].cyc < ncyc) begin
        total++;
        bad++;
        $display("FAIL %s: expectation for cycle %0d never checked", sbq[k].name, sbq[k].cyc);
        sbq.delete(k);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input int cyc, input int kind, input logic [7:0] com,
                      input logic [7:0] data, input logic busy, input string nm);
    item_t it;
    it.cyc = cyc; it.kind = kind; it.com = com; it.data = data; it.busy = busy; it.name = nm;
    sbq.push_back(it);
  endtask

  task automatic set_buf(input logic [15:0] left, input logic [15:0] right);
    for (int i = 0; i < 4; i++) begin
      m_buf[i]     = right[4*i +: 4];
      m_buf[i + 4] = left[4*i +: 4];
    end
  endtask

  // One tick_scan (optionally with tick_blink); expectation lands one clk later.
  task automatic scan(input bit chk, input bit blk);
    logic [7:0] ecom;
    logic [7:0] edata;
    logic       off;
    i_tick_scan  = 1'b1;
    i_tick_blink = blk;
    @(posedge i_clk); #1;
    i_tick_scan  = 1'b0;
    i_tick_blink = 1'b0;
    m_idx = (m_idx + 1) % 8;
    if (blk) m_blink = ~m_blink;
    if (chk) begin
      ecom  = ~(8'h01 << m_idx);
      off   = m_blink && ((m_idx >= 4) ? i_warn_mask[1] : i_warn_mask[0]);
      edata = off ? 8'h00 : seg_tab[m_buf[m_idx]];
      push(ncyc + 1, 0, ecom, edata, 1'b0, $sformatf("scan_d%0d", m_idx));
    end
  endtask

  task automatic frame(input bit chk);
    for (int i = 0; i < 8; i++) scan(chk, 1'b0);
  endtask

  task automatic pulse_blink();
    i_tick_blink = 1'b1;
    @(posedge i_clk); #1;
    i_tick_blink = 1'b0;
    m_blink = ~m_blink;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (o_conv_busy && (n < 200)) begin
      @(posedge i_clk); #1;
      n++;
    end
    push(ncyc, 1, 8'h00, 8'h00, 1'b0, nm);
  endtask

  task automatic reset_model();
    m_idx   = 0;
    m_blink = 1'b0;
    set_buf(16'hFFFF, 16'hFFFF);
  endtask

  initial begin
    int c;
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h00};
    rot_l = '{16'hFF22, 16'h9999, 16'h9999, 16'hFF55, 16'hFF55, 16'hFF22};
    rot_r = '{16'hFF11, 16'hFF44, 16'hFF44, 16'hFF44, 16'hFF44, 16'hFF11};
    i_rst_n = 1'b0; i_tick_scan = 1'b0; i_tick_blink = 1'b0; i_page_sel = 2'd0;
    i_rpm = 14'd0; i_speed = 8'd0; i_fuel = 8'd0; i_temp = 8'd0; i_accel = 8'd0;
    i_warn_mask = 2'b00;
    reset_model();
    repeat (3) @(posedge i_clk);
    #1;
    push(ncyc, 2, 8'hFF, 8'h00, 1'b0, "reset_state");
    i_rst_n = 1'b1;

    // Page 0: accel=5 | speed=120.
    i_accel = 8'd5; i_speed = 8'd120;
    frame(1'b0);
    wait_idle("t1_idle");
    set_buf(16'hFFF5, 16'hF120);
    frame(1'b1);

    // Page 1: rpm saturates, temp=0 shows a lone "0".
    wait_idle("t2_pre");
    i_page_sel = 2'd1; i_rpm = 14'd12345; i_temp = 8'd0;
    frame(1'b0);
    wait_idle("t2_idle");
    set_buf(16'h9999, 16'hFFF0);
    frame(1'b1);

    // Latency and ignored boundary; inputs change after the snapshot.
    wait_idle("t3_pre");
    i_page_sel = 2'd2; i_fuel = 8'd100; i_temp = 8'd8;
    repeat (7) scan(1'b0, 1'b0);
    scan(1'b0, 1'b0);
    c = ncyc;
    push(c,      1, 8'h00, 8'h00, 1'b1, "busy_start");
    push(c + 31, 1, 8'h00, 8'h00, 1'b1, "busy_last");
    push(c + 32, 1, 8'h00, 8'h00, 1'b0, "busy_commit32");
    push(c + 33, 1, 8'h00, 8'h00, 1'b0, "busy_no_retrigger");
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_fuel = 8'd42; i_temp = 8'd33;
    frame(1'b0);
    wait_idle("t3_idle");
    set_buf(16'hF100, 16'hFFF8);
    frame(1'b1);

    // Left-half warning blink; second toggle coincides with a scan tick.
    wait_idle("t4_idle");
    set_buf(16'hFF42, 16'hFF33);
    i_warn_mask = 2'b10;
    pulse_blink();
    frame(1'b1);
    scan(1'b1, 1'b1);
    repeat (7) scan(1'b1, 1'b0);
    i_warn_mask = 2'b00;

    // Auto-rotate with ROT_FRAMES=2.
    wait_idle("t5_pre");
    i_speed = 8'd11; i_accel = 8'd22; i_rpm = 14'd9999; i_temp = 8'd44; i_fuel = 8'd55;
    i_page_sel = 2'd3;
    frame(1'b0);
    for (int j = 0; j < 6; j++) begin
      wait_idle($sformatf("rot_idle%0d", j));
      set_buf(rot_l[j], rot_r[j]);
      frame(1'b1);
    end

    // Reset in the middle of the right-half shift.
    wait_idle("t6_pre");
    i_page_sel = 2'd0; i_accel = 8'd200; i_speed = 8'd3;
    repeat (7) scan(1'b0, 1'b0);
    scan(1'b0, 1'b0);
    repeat (20) begin
      @(posedge i_clk); #1;
    end
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    push(ncyc, 2, 8'hFF, 8'h00, 1'b0, "mid_reset");
    i_rst_n = 1'b1;
    reset_model();
    frame(1'b1);
    wait_idle("t6_idle");
    set_buf(16'hF200, 16'hFFF3);
    frame(1'b1);

    repeat (3) @(posedge i_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised successor to the dashboard 8-digit display driver.
- Time-multiplexes NUM_DIGITS common-cathode-style digits (active-high segments, active-low commons), split into a left half and a right half.
- Binary-to-BCD conversion is a serial double-dabble FSM instead of combinational divide. Converted digits are double-buffered and committed atomically at frame boundaries.
- Adds a third data page, an auto-rotate page mode and per-half warning blink.
- Sits between the vehicle-state registers and the board 7-segment pins.

Parameters:
- NUM_DIGITS, 8, total digits; even, 4..8. H = NUM_DIGITS/2 digits per half.
- VAL_W, 14, width of the widest input value (rpm); all inputs are zero-extended to VAL_W.
- ROT_FRAMES, 512, complete scan frames per page in auto-rotate mode; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- tick_scan  in  1  one-cycle strobe; advances the scan digit.
- tick_blink  in  1  one-cycle strobe; toggles the blink phase.
- page_sel  in  2  page select: 0 = accel|speed, 1 = rpm|temp, 2 = fuel|temp, 3 = auto-rotate.
- rpm  in  14  engine rpm.
- speed  in  8  vehicle speed.
- fuel  in  8  fuel level.
- temp  in  8  engine temperature.
- accel  in  8  accelerator strength.
- warn_mask  in  2  bit1 blinks the left half, bit0 blinks the right half.
- seg_data  out  8  segment pattern, active-high, bit7 = dp (always 0).
- seg_com  out  NUM_DIGITS  digit commons, active-low, one-hot-low.
- conv_busy  out  1  high while the converter FSM is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - seg_data=0, seg_com=all ones, conv_busy=0.
  - scan_idx=0, blink_phase=0, rot_page=0, frame counter=0.
  - Display buffer = all blank code 4'hF.
  - Converter returns to IDLE immediately; a partial result is discarded and never committed.
- Scan:
  - scan_idx increments on tick_scan and wraps NUM_DIGITS-1 → 0.
  - Outputs are registered, one clk after the scan_idx change.
  - seg_com[scan_idx]=0, all other bits 1.
  - Digits 0..H-1 show the right half (LSD at 0); digits H..NUM_DIGITS-1 show the left half.
- Frame boundary: tick_scan while scan_idx==NUM_DIGITS-1.
- Page resolution:
  - page_sel 0..2 select the page directly.
  - page_sel 3 uses rot_page, which advances 0→1→2→0 after ROT_FRAMES frame boundaries.
  - The frame counter clears when page_sel≠3.
- Converter FSM, states IDLE, LOAD_L, SHIFT_L, LOAD_R, SHIFT_R, BLANK, COMMIT:
  - IDLE→LOAD_L on a frame boundary. Left and right values are snapshotted in LOAD_L.
  - SHIFT_x runs exactly VAL_W cycles of double-dabble (add 3 to any BCD nibble ≥5, then shift).
  - Saturation: a value > 10^H − 1 becomes all 9s, i.e. 9999 for H=4.
  - BLANK: leading zeros become 4'hF, MSD first, stopping at the first nonzero digit. The LSD is never blanked, so value 0 shows "0".
  - COMMIT writes both halves into the display buffer in one cycle, then → IDLE.
  - Latency from frame boundary to commit: 2·(VAL_W+1)+2 clk.
  - A frame boundary arriving while busy is ignored; there is no queueing.
  - Inputs may change freely during conversion; only the snapshot is used.
- Segment encoding:
  - 0..9 and A..E as standard active-high patterns; 4'hF outputs 8'h00.
  - If blink_phase=1 and the warn_mask bit of the current half is set, seg_data=0 for that half's digits. seg_com still scans.
- Simultaneous events:
  - rst_n low has priority over everything.
  - tick_scan and tick_blink in the same cycle are both applied.
  - COMMIT coinciding with tick_scan: the new buffer is visible from the next registered output.

Optional Feature:
- SEG_LAMP_TEST_EN defined:
  - Adds input port lamp_test (1 bit).
  - While lamp_test=1, seg_data=8'hFF on every scanned digit. This overrides blank and blink.
  - Scanning and conversion continue.
- Macro undefined: the port is absent and no override logic is built.

Decomposition:
- Package seg_disp_pkg holds:
  - page encodings PAGE_NORMAL=0, PAGE_OBD=1, PAGE_FUEL=2, PAGE_AUTO=3;
  - BLANK_CODE=4'hF;
  - the 16-entry segment table/function;
  - FSM state enum.
- Sub-module bin2bcd_serial (VAL_W, H): start/done handshake, saturation, blanking. It is instantiated once and reused for the left then right half.

Test Plan:
- NUM_DIGITS=8, page 0, accel=5, speed=120, after commit → right digits 0,1,2,3 = "0","2","1",blank; left = "5", blank, blank, blank; seg_com walks FE,FD,…,7F.
- page 1, rpm=12345, temp=0 → left shows 9,9,9,9 (saturated); right shows "0" in digit 0 and blanks in digits 1..3.
- Assert conv_busy at a frame boundary, then pulse another frame boundary 5 clk later → ignored; commit occurs exactly 32 clk after the first boundary (VAL_W=14).
- warn_mask=2'b10, pulse tick_blink once → left digits seg_data=0, right digits unchanged; second pulse → left restored.
- page_sel=3, ROT_FRAMES=2 → display shows page 0, then 1, then 2, then 0, each for 2 frames (plus commit latency).
- Drive rst_n=0 for one clk during SHIFT_R → next cycle conv_busy=0, seg_com=all ones, seg_data=0, buffer blank; nothing is committed until the next full conversion.
